// File: rtl/lsg_pkg.sv
// -----------------------------------------------------------------------------
// lsg_pkg
// Shared types and constants for the lane strobe generator.
//   seq_state_e    : logical-layer reset sequencer states
//   INC_*          : NCO increments for an 80 GHz local_clk at ACC_W = 32.
//                    Strobe rate = inc / 2^32 * 80 GHz.
// Used by: lsg_nco_ch, lane_strobe_gen
// -----------------------------------------------------------------------------
package lsg_pkg;

    typedef enum logic {
        HOLD     = 1'b0,
        RELEASED = 1'b1
    } seq_state_e;

    // Sideband at 800 MHz: 2^32 / 100, rounded to nearest.
    localparam logic [31:0] INC_SB        = 32'd42949673;

    // Lane rates: Gen2 10 GHz, Gen3 20 GHz, Gen4 40 GHz.
    localparam logic [31:0] INC_GEN2_LANE = 32'h2000_0000;
    localparam logic [31:0] INC_GEN3_LANE = 32'h4000_0000;
    localparam logic [31:0] INC_GEN4_LANE = 32'h8000_0000;

    // FSM rates run at lane rate / 8.
    localparam logic [31:0] INC_GEN2_FSM  = 32'h0400_0000;
    localparam logic [31:0] INC_GEN3_FSM  = 32'h0800_0000;

endpackage

// File: rtl/lsg_nco_ch.sv
// -----------------------------------------------------------------------------
// lsg_nco_ch
// One fractional-rate strobe channel (phase accumulator / NCO).
// Optional macro: LSG_STROBE_CNT_EN adds a per-channel strobe counter.
//
// Ports
//   clk     in   : local clock
//   rst     in   : synchronous active-high reset
//   en      in   : accumulate enable; when low, phase and toggle hold
//   inc_in  in   : increment presented for loading
//   load    in   : load inc_in into the active increment (takes effect next edge)
//   sync    in   : with load, clears phase, strobe, toggle and counter
//   strobe  out  : registered one-cycle carry-out of the accumulator
//   tog     out  : inverts on each strobe (divided-clock view)
//   cnt     out  : strobe count, wraps (LSG_STROBE_CNT_EN only)
// -----------------------------------------------------------------------------
module lsg_nco_ch
    import lsg_pkg::*;
#(
    parameter int ACC_W = 32
`ifdef LSG_STROBE_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] inc_in,
    input  logic             load,
    input  logic             sync,
    output logic             strobe,
    output logic             tog
`ifdef LSG_STROBE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             clear;

    // One extra bit holds the carry that becomes the strobe.
    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign clear = load & sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            inc    <= '0;
            strobe <= 1'b0;
            tog    <= 1'b0;
        end else begin
            // The add on a load edge still uses the old increment.
            if (load) begin
                inc <= inc_in;
            end

            if (clear) begin
                // Phase restart swallows any overflow on this edge.
                acc    <= '0;
                strobe <= 1'b0;
                tog    <= 1'b0;
            end else if (en) begin
                acc    <= sum[ACC_W-1:0];
                strobe <= sum[ACC_W];
                if (sum[ACC_W]) begin
                    tog <= ~tog;
                end
            end else begin
                strobe <= 1'b0;
            end
        end
    end

`ifdef LSG_STROBE_CNT_EN
    // Counts cycles in which the registered strobe is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/lane_strobe_gen.sv
// -----------------------------------------------------------------------------
// lane_strobe_gen
// NUM_CH programmable rate strobes derived from local_clk by phase
// accumulators, plus the logical-layer reset release sequencer timed in
// strobes of channel REF_CH. Everything stays in the local_clk domain; the
// strobes are clock enables, not clocks.
// Optional macro: LSG_STROBE_CNT_EN adds CNT_W and the strobe_cnt_o port.
//
// Ports
//   local_clk       in   : single clock
//   rst             in   : synchronous active-high reset
//   ch_en_i         in   : per-channel enable
//   ch_inc_i        in   : per-channel increment, channel k at [k*ACC_W +: ACC_W]
//   ch_load_i       in   : per-channel increment load pulse
//   ch_sync_i       in   : with load, clears the channel phase
//   soft_rst_req_i  in   : restarts the reset hold
//   strobe_o        out  : one-cycle rate strobes
//   tog_o           out  : toggles on each strobe
//   lrst_n_o        out  : active-low logical-layer reset
//   seq_busy_o      out  : high while the sequencer holds reset
//   strobe_cnt_o    out  : per-channel strobe counts (LSG_STROBE_CNT_EN only)
//
// Sequencer states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   HOLD     | lrst_n_o low; counting REF_CH strobes up to RST_HOLD
//   RELEASED | lrst_n_o high; waiting for soft_rst_req_i
// -----------------------------------------------------------------------------
module lane_strobe_gen
    import lsg_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 32,
    parameter int REF_CH   = 0,
    parameter int RST_HOLD = 3
`ifdef LSG_STROBE_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                    local_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH*ACC_W-1:0] ch_inc_i,
    input  logic [NUM_CH-1:0]       ch_load_i,
    input  logic [NUM_CH-1:0]       ch_sync_i,
    input  logic                    soft_rst_req_i,
    output logic [NUM_CH-1:0]       strobe_o,
    output logic [NUM_CH-1:0]       tog_o,
    output logic                    lrst_n_o,
    output logic                    seq_busy_o
`ifdef LSG_STROBE_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] strobe_cnt_o
`endif
);

    // Hold count only needs to reach RST_HOLD-1; the last strobe releases.
    localparam int              HC_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);

    // -------------------------------------------------------------------------
    // Strobe channels
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        lsg_nco_ch #(
            .ACC_W (ACC_W)
`ifdef LSG_STROBE_CNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_ch (
            .clk    (local_clk),
            .rst    (rst),
            .en     (ch_en_i[k]),
            .inc_in (ch_inc_i[k*ACC_W +: ACC_W]),
            .load   (ch_load_i[k]),
            .sync   (ch_sync_i[k]),
            .strobe (strobe_o[k]),
            .tog    (tog_o[k])
`ifdef LSG_STROBE_CNT_EN
            ,
            .cnt    (strobe_cnt_o[k*CNT_W +: CNT_W])
`endif
        );
    end

    // -------------------------------------------------------------------------
    // Reset sequencer
    // -------------------------------------------------------------------------
    seq_state_e      state;
    seq_state_e      state_nxt;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_cnt_nxt;
    logic            ref_strobe;

    assign ref_strobe = strobe_o[REF_CH];

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        lrst_n_o     = 1'b0;
        seq_busy_o   = 1'b1;

        case (state)
            HOLD: begin
                // A restart request beats a strobe on the same edge.
                if (soft_rst_req_i) begin
                    hold_cnt_nxt = '0;
                end else if (ref_strobe) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt    = RELEASED;
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HC_W'(1);
                    end
                end
            end
            RELEASED: begin
                lrst_n_o   = 1'b1;
                seq_busy_o = 1'b0;
                if (soft_rst_req_i) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = HOLD;
                hold_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: doc/lane_strobe_gen.md
Name: lane_strobe_gen

Overview:
- Parametrised successor to the bench's fixed per-generation clock dividers.
- Derives NUM_CH programmable rate strobes (SB, Gen2/3/4 lane and FSM rates) from the single local_clk, using fractional phase accumulators (NCOs).
- Also sequences the logical-layer active-low reset release, timed in strobes of a reference channel.
- Sits beside logical_layer. Replaces free-running divided clocks with clock enables, so the whole domain stays single-clock.

Parameters:
- NUM_CH, 4: number of strobe channels.
- ACC_W, 32: accumulator and increment width. Strobe rate = inc / 2^ACC_W × f(local_clk).
- REF_CH, 0: channel whose strobes time the reset sequencer (sideband rate).
- RST_HOLD, 3: number of REF_CH strobes for which lrst_n_o is held low.
- CNT_W, 16: strobe counter width (optional feature only).

Ports:
- local_clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- ch_en_i, in, NUM_CH: per-channel enable.
- ch_inc_i, in, NUM_CH*ACC_W: increment per channel; channel k occupies bits [k*ACC_W +: ACC_W].
- ch_load_i, in, NUM_CH: per-channel pulse that loads ch_inc_i into the active increment.
- ch_sync_i, in, NUM_CH: qualifies load; clears accumulator phase.
- soft_rst_req_i, in, 1: pulse that restarts the reset sequence.
- strobe_o, out, NUM_CH: one-cycle rate strobe per channel.
- tog_o, out, NUM_CH: toggles on each strobe (50% duty divided-clock view).
- lrst_n_o, out, 1: active-low reset to the logical layer.
- seq_busy_o, out, 1: high while the sequencer is in HOLD.
- strobe_cnt_o, out, NUM_CH*CNT_W: present only with LSG_STROBE_CNT_EN.

Behaviour:
- Reset (rst=1 at an edge): acc=0, inc=0, strobe_o=0, tog_o=0, lrst_n_o=0, seq_busy_o=1, sequencer state=HOLD, hold count=0, strobe_cnt_o=0.
- Per channel, at each edge with ch_en_i[k]=1: {carry, acc} = acc + inc, computed to ACC_W+1 bits. strobe_o[k] <= carry. tog_o[k] inverts when carry=1.
  - Strobe is registered: it is high for the cycle after the overflowing edge.
  - No strobe ever lasts more than one cycle. inc=0 gives no strobes.
  - The maximum rate is reached at inc = 2^ACC_W − 1; 2^ACC_W is not representable.
- ch_en_i[k]=0: acc and tog hold; strobe_o[k]=0.
- ch_load_i[k]=1: inc <= ch_inc_i slice.
  - The add on that same edge uses the old inc. The new inc takes effect from the next edge.
  - Load is honoured even when the channel is disabled.
- ch_load_i[k]=1 with ch_sync_i[k]=1: acc <= 0, strobe_o[k] <= 0 (any overflow on that edge is suppressed), tog_o[k] <= 0.
- ch_sync_i without ch_load_i has no effect.
- Sequencer states and transitions:
  - HOLD: lrst_n_o=0, seq_busy_o=1. Each edge that samples strobe_o[REF_CH]=1 increments the hold count.
  - HOLD -> RELEASED: at the edge that samples the RST_HOLD-th strobe. At that edge lrst_n_o <= 1, seq_busy_o <= 0, count <= 0.
  - RELEASED -> HOLD: soft_rst_req_i=1. lrst_n_o <= 0 at that edge, count cleared.
  - soft_rst_req_i in HOLD: count cleared; the hold restarts. It wins over a simultaneous strobe.
  - REF_CH disabled or inc=0: the sequencer stays in HOLD indefinitely. There is no timeout.
- rst mid-operation: all state returns to reset values at that edge, regardless of the current state.

Optional Feature:
- LSG_STROBE_CNT_EN defined: a per-channel CNT_W-bit counter increments on each cycle where strobe_o[k]=1.
  - It wraps from 2^CNT_W−1 to 0.
  - It is cleared by rst and by load+sync on that channel.
  - It is presented on strobe_cnt_o.
- LSG_STROBE_CNT_EN undefined: the port and the counters are absent.

Decomposition:
- Package lsg_pkg holds:
  - typedef seq_state_e {HOLD, RELEASED};
  - localparam increment constants for 80 GHz local_clk at ACC_W=32: INC_SB, INC_GEN2_LANE (2^32/8), INC_GEN3_LANE (2^32/4), INC_GEN4_LANE (2^32/2), INC_GEN2_FSM, INC_GEN3_FSM.
- One sub-module, lsg_nco_ch: accumulator, increment register, strobe, toggle and optional counter. It is instantiated NUM_CH times in a generate loop. The sequencer lives in the top module.

Test Plan:
- Strobe period: inc=0x4000_0000 loaded with sync, ch_en=1 -> strobe_o high exactly every 4th cycle. tog_o period is 8 cycles.
- Fractional rate: inc=0x6000_0000 -> exactly 3 strobes per any 8-cycle window after sync. Pattern repeats every 8 cycles.
- Simultaneous load and overflow: acc=0xC000_0000, inc=0x4000_0000; load 0x2000_0000 without sync on the overflowing edge -> strobe still issued. The next strobe comes 8 cycles later.
- Reset sequence: RST_HOLD=3, REF inc=0x4000_0000 loaded with sync at edge 1 after rst falls -> strobes after edges 5, 9, 13. lrst_n_o rises at edge 14.
- Soft reset and disable: soft_rst_req_i in RELEASED -> lrst_n_o=0 at the next edge and re-releases after 3 strobes. With REF disabled, lrst_n_o stays 0 for 1000 cycles.
- Counter (LSG_STROBE_CNT_EN, CNT_W=4): 17 strobes -> strobe_cnt_o=1. Load+sync -> 0.
